// File: rtl/keylock_pkg.sv
// Shared types and constants for the keylock sequencing controller.
package keylock_pkg;

  localparam int unsigned DIGIT_BASE = 10;
  localparam int unsigned CODE_W     = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_OPEN    = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;

  // Ceiling log2; callers pass max+1 so the result is a counter width.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((33'(1) << i) < 33'(v)) r = 32'(i + 1);
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/keylock_timer.sv
// Loadable down-counter shared by the unlock window and the lockout window.
module keylock_timer #(
  parameter int unsigned W = 13
) (
  input  logic         hwclk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] load_val,
  output logic         done_c
);

  logic [W-1:0] count_q;

  // Load on start, otherwise count down to zero and park there.
  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (start) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  // Asserted during the last cycle of the loaded window.
  assign done_c = (count_q == W'(1));

endmodule

// File: rtl/keylock_ctrl.sv
// Keylock sequencing controller: digit accumulation, compare request,
// unlock window, failure counting and optional lockout.
// Build option: define KEYLOCK_LOCKOUT_EN to enable the LOCKOUT state;
// otherwise locked_out is tied low and every failure returns to IDLE.
module keylock_ctrl
  import keylock_pkg::*;
#(
  parameter int unsigned MAX_DIGITS     = 8,
  parameter int unsigned UNLOCK_CYCLES  = 1000,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 5000
) (
  input  logic              hwclk,
  input  logic              rst_n,
  input  logic              key_valid,
  input  logic [3:0]        key_digit,
  input  logic              key_enter,
  input  logic              key_clear,
  output logic [CODE_W-1:0] cmp_in,
  output logic              cmp_req,
  input  logic              cmp_done,
  input  logic              cmp_match,
  output logic              unlock,
  output logic              locked_out,
  output logic [3:0]        fail_cnt,
  output logic [3:0]        digit_cnt,
  output logic              busy
);

  localparam int unsigned TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES
                                                                     : LOCKOUT_CYCLES;
  localparam int unsigned TMR_W   = clog2(TMR_MAX + 1);
  localparam logic [3:0]  MAX_D4  = 4'(MAX_DIGITS);

  // Reject parameter values that would break the 32-bit accumulation or counters.
  if (MAX_DIGITS < 1 || MAX_DIGITS > 9 || MAX_FAILS < 1 ||
      UNLOCK_CYCLES < 1 || LOCKOUT_CYCLES < 1) begin : g_param_err
    $error("keylock_ctrl: illegal parameter value");
  end

  state_e            state_q, state_d;
  logic [CODE_W-1:0] cmp_in_d;
  logic [3:0]        digit_d, fail_d, fail_inc;
  logic              ovf_q, ovf_d;
  logic              req_d;
  logic              digit_ok;
  logic              fail_event;
  logic              tmr_start;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_done_c;

  keylock_timer #(.W(TMR_W)) u_timer (
    .hwclk    (hwclk),
    .rst_n    (rst_n),
    .start    (tmr_start),
    .load_val (tmr_val),
    .done_c   (tmr_done_c)
  );

  assign digit_ok = key_valid && (key_digit <= 4'd9);
  assign fail_inc = (fail_cnt == 4'hF) ? 4'hF : fail_cnt + 4'd1;

  // Next-state and next-register-value logic.
  always_comb begin
    state_d    = state_q;
    cmp_in_d   = cmp_in;
    digit_d    = digit_cnt;
    ovf_d      = ovf_q;
    fail_d     = fail_cnt;
    req_d      = 1'b0;
    fail_event = 1'b0;
    tmr_start  = 1'b0;
    tmr_val    = TMR_W'(UNLOCK_CYCLES);

    case (state_q)
      ST_IDLE: begin
        if (!key_clear && !key_enter && digit_ok) begin
          cmp_in_d = CODE_W'(key_digit);
          digit_d  = 4'd1;
          state_d  = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (key_clear) begin
          cmp_in_d = '0;
          digit_d  = 4'd0;
          ovf_d    = 1'b0;
          state_d  = ST_IDLE;
        end else if (key_enter) begin
          if (ovf_q) begin
            fail_event = 1'b1;
          end else begin
            req_d   = 1'b1;
            state_d = ST_CHECK;
          end
        end else if (digit_ok) begin
          if (digit_cnt < MAX_D4) begin
            cmp_in_d = cmp_in * CODE_W'(DIGIT_BASE) + CODE_W'(key_digit);
            digit_d  = digit_cnt + 4'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      ST_CHECK: begin
        if (key_clear) begin
          cmp_in_d = '0;
          digit_d  = 4'd0;
          ovf_d    = 1'b0;
          state_d  = ST_IDLE;
        end else if (cmp_done) begin
          if (cmp_match) begin
            fail_d    = 4'd0;
            tmr_start = 1'b1;
            state_d   = ST_OPEN;
          end else begin
            fail_event = 1'b1;
          end
        end
      end
      ST_OPEN: begin
        if (tmr_done_c) begin
          cmp_in_d = '0;
          digit_d  = 4'd0;
          ovf_d    = 1'b0;
          state_d  = ST_IDLE;
        end
      end
`ifdef KEYLOCK_LOCKOUT_EN
      ST_LOCKOUT: begin
        if (tmr_done_c) begin
          fail_d  = 4'd0;
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Failure handling shared by the overflow path and the no-match path.
    if (fail_event) begin
      fail_d   = fail_inc;
      cmp_in_d = '0;
      digit_d  = 4'd0;
      ovf_d    = 1'b0;
      state_d  = ST_IDLE;
`ifdef KEYLOCK_LOCKOUT_EN
      if (32'(fail_inc) >= MAX_FAILS) begin
        tmr_start = 1'b1;
        tmr_val   = TMR_W'(LOCKOUT_CYCLES);
        state_d   = ST_LOCKOUT;
      end
`endif
    end
  end

  // State and registered outputs; unlock drops as soon as reset asserts.
  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cmp_in    <= '0;
      digit_cnt <= 4'd0;
      ovf_q     <= 1'b0;
      fail_cnt  <= 4'd0;
      cmp_req   <= 1'b0;
      unlock    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmp_in    <= cmp_in_d;
      digit_cnt <= digit_d;
      ovf_q     <= ovf_d;
      fail_cnt  <= fail_d;
      cmp_req   <= req_d;
      unlock    <= (state_d == ST_OPEN);
      busy      <= (state_d == ST_CHECK) || (state_d == ST_OPEN) ||
                   (state_d == ST_LOCKOUT);
    end
  end

`ifdef KEYLOCK_LOCKOUT_EN
  // Lockout indicator follows the LOCKOUT state.
  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) locked_out <= 1'b0;
    else        locked_out <= (state_d == ST_LOCKOUT);
  end
`else
  assign locked_out = 1'b0;
`endif

endmodule

// File: tb/tb_keylock_ctrl.sv
// Self-checking bench for keylock_ctrl with a compare responder and
// a scoreboard for compare requests, unlock and lockout windows.
module tb_keylock_ctrl;

  localparam logic [31:0] CODE = 32'd555116;

  logic        hwclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_digit = 4'd0;
  logic        key_enter = 1'b0;
  logic        key_clear = 1'b0;
  logic [31:0] cmp_in;
  logic        cmp_req;
  logic        cmp_done = 1'b0;
  logic        cmp_match = 1'b0;
  logic        unlock;
  logic        locked_out;
  logic [3:0]  fail_cnt;
  logic [3:0]  digit_cnt;
  logic        busy;

  int checks = 0;
  int errors = 0;
  bit cmp_hold = 1'b0;

  int exp_req_q[$];
  int exp_unlock_q[$];
  int exp_lock_q[$];

  keylock_ctrl dut (
    .hwclk      (hwclk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_digit  (key_digit),
    .key_enter  (key_enter),
    .key_clear  (key_clear),
    .cmp_in     (cmp_in),
    .cmp_req    (cmp_req),
    .cmp_done   (cmp_done),
    .cmp_match  (cmp_match),
    .unlock     (unlock),
    .locked_out (locked_out),
    .fail_cnt   (fail_cnt),
    .digit_cnt  (digit_cnt),
    .busy       (busy)
  );

  always #5 hwclk = ~hwclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive one cycle of keypad strobes; entered and left at posedge+1.
  task automatic drive(input logic v, input logic [3:0] d, input logic e, input logic c);
    key_valid = v; key_digit = d; key_enter = e; key_clear = c;
    @(posedge hwclk); #1;
    key_valid = 1'b0; key_digit = 4'd0; key_enter = 1'b0; key_clear = 1'b0;
  endtask

  task automatic press(input logic [3:0] d);
    drive(1'b1, d, 1'b0, 1'b0);
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return unlock;
      1:       return busy;
      default: return locked_out;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input logic val, input int lim, input string nm);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < lim && !hit; i++) begin
      @(posedge hwclk); #1;
      if (sig(sel) == val) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s: timeout after %0d cycles, signal never reached %0b", nm, lim, val);
    end
  endtask

  // Comparator model: answers each request two cycles later.
  initial begin
    forever begin
      @(negedge hwclk);
      if (cmp_req && !cmp_hold) begin
        repeat (2) @(posedge hwclk);
        #1;
        cmp_done  = 1'b1;
        cmp_match = (cmp_in == CODE);
        @(posedge hwclk); #1;
        cmp_done  = 1'b0;
        cmp_match = 1'b0;
      end
    end
  end

  // Monitor: compare requests and window lengths against the scoreboard.
  int  ucnt = 0;
  int  lcnt = 0;
  bit  uprev = 1'b0;
  bit  lprev = 1'b0;
  always @(negedge hwclk) begin
    if (!rst_n) begin
      ucnt = 0; lcnt = 0; uprev = 1'b0; lprev = 1'b0;
    end else begin
      if (cmp_req) begin
        checks++;
        if (exp_req_q.size() == 0) begin
          errors++;
          $display("FAIL cmp_req: unexpected request with cmp_in=%0d", cmp_in);
        end else begin
          int e;
          e = exp_req_q.pop_front();
          chk("cmp_req_value", cmp_in, 32'(e));
        end
      end
      if (unlock) ucnt++;
      else if (uprev) begin
        checks++;
        if (exp_unlock_q.size() == 0) begin
          errors++;
          $display("FAIL unlock_len: unexpected window of %0d cycles", ucnt);
        end else begin
          int e;
          e = exp_unlock_q.pop_front();
          chk("unlock_len", 32'(ucnt), 32'(e));
        end
        ucnt = 0;
      end
      if (locked_out) lcnt++;
      else if (lprev) begin
        checks++;
        if (exp_lock_q.size() == 0) begin
          errors++;
          $display("FAIL lock_len: unexpected window of %0d cycles", lcnt);
        end else begin
          int e;
          e = exp_lock_q.pop_front();
          chk("lock_len", 32'(lcnt), 32'(e));
        end
        lcnt = 0;
      end
      uprev = unlock;
      lprev = locked_out;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] steps [6];
    logic [3:0]  code_d [6];
    steps  = '{32'd5, 32'd55, 32'd555, 32'd5551, 32'd55511, 32'd555116};
    code_d = '{4'd5, 4'd5, 4'd5, 4'd1, 4'd1, 4'd6};

    // Reset values
    #3;
    chk("rst_cmp_in", cmp_in, 32'd0);
    chk("rst_unlock", 32'(unlock), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fail_cnt", 32'(fail_cnt), 32'd0);
    repeat (2) @(posedge hwclk);
    #1 rst_n = 1'b1;
    @(posedge hwclk); #1;

    // Enter and clear in IDLE do nothing; out-of-range digit ignored
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    press(4'd12);
    chk("idle_ignore_digit_cnt", 32'(digit_cnt), 32'd0);
    chk("idle_ignore_busy", 32'(busy), 32'd0);

    // Correct code
    for (int i = 0; i < 6; i++) begin
      press(code_d[i]);
      chk($sformatf("acc_step%0d", i), cmp_in, steps[i]);
    end
    chk("acc_digit_cnt", 32'(digit_cnt), 32'd6);
    exp_req_q.push_back(555116);
    exp_unlock_q.push_back(1000);
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    chk("check_busy", 32'(busy), 32'd1);
    wait_sig(0, 1'b1, 20, "unlock_rise");
    press(4'd3);
    chk("open_ignores_keys", cmp_in, 32'd555116);
    wait_sig(0, 1'b0, 1100, "unlock_fall");
    chk("open_exit_cmp_in", cmp_in, 32'd0);
    chk("open_exit_busy", 32'(busy), 32'd0);

    // Wrong code
    for (int i = 0; i < 6; i++) press(code_d[i]);
    press(4'd1);
    chk("wrong_cmp_in", cmp_in, 32'd5551161);
    exp_req_q.push_back(5551161);
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    wait_sig(1, 1'b0, 20, "wrong_done");
    chk("wrong_fail_cnt", 32'(fail_cnt), 32'd1);
    chk("wrong_unlock", 32'(unlock), 32'd0);
    chk("wrong_cmp_in_cleared", cmp_in, 32'd0);

    // Overflow: 10 digits, only 8 kept, failure without a request
    for (int i = 0; i < 10; i++) press(4'd1);
    chk("ovf_cmp_in", cmp_in, 32'd11111111);
    chk("ovf_digit_cnt", 32'(digit_cnt), 32'd8);
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    chk("ovf_fail_cnt", 32'(fail_cnt), 32'd2);
    chk("ovf_busy", 32'(busy), 32'd0);
    chk("ovf_cleared", cmp_in, 32'd0);

    // Clear beats enter in ENTRY
    press(4'd4);
    drive(1'b0, 4'd0, 1'b1, 1'b1);
    repeat (3) @(posedge hwclk);
    #1;
    chk("prio_digit_cnt", 32'(digit_cnt), 32'd0);
    chk("prio_busy", 32'(busy), 32'd0);

    // Clear aborts CHECK
    cmp_hold = 1'b1;
    press(4'd9); press(4'd9);
    exp_req_q.push_back(99);
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    repeat (3) @(posedge hwclk);
    #1;
    chk("abort_busy_before", 32'(busy), 32'd1);
    drive(1'b0, 4'd0, 1'b0, 1'b1);
    chk("abort_busy_after", 32'(busy), 32'd0);
    chk("abort_fail_cnt", 32'(fail_cnt), 32'd2);
    chk("abort_cmp_in", cmp_in, 32'd0);
    cmp_hold = 1'b0;

    // Third failure
    press(4'd1); press(4'd2);
    exp_req_q.push_back(12);
`ifdef KEYLOCK_LOCKOUT_EN
    exp_lock_q.push_back(5000);
`endif
    drive(1'b0, 4'd0, 1'b1, 1'b0);
`ifdef KEYLOCK_LOCKOUT_EN
    wait_sig(2, 1'b1, 20, "lock_rise");
    chk("lock_fail_cnt", 32'(fail_cnt), 32'd3);
    press(4'd7);
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    drive(1'b0, 4'd0, 1'b0, 1'b1);
    chk("lock_ignore_digit", 32'(digit_cnt), 32'd0);
    chk("lock_still_locked", 32'(locked_out), 32'd1);
    wait_sig(2, 1'b0, 5100, "lock_fall");
    chk("lock_exit_fail_cnt", 32'(fail_cnt), 32'd0);
    chk("lock_exit_busy", 32'(busy), 32'd0);
`else
    wait_sig(1, 1'b0, 20, "third_done");
    chk("nolock_fail_cnt", 32'(fail_cnt), 32'd3);
    chk("nolock_locked_out", 32'(locked_out), 32'd0);
    // Keep failing to reach saturation
    for (int n = 0; n < 13; n++) begin
      press(4'd7);
      exp_req_q.push_back(7);
      drive(1'b0, 4'd0, 1'b1, 1'b0);
      wait_sig(1, 1'b0, 20, "sat_done");
    end
    chk("nolock_fail_sat", 32'(fail_cnt), 32'd15);
`endif

    // Reset during OPEN, 500 cycles into the window
    for (int i = 0; i < 6; i++) press(code_d[i]);
    exp_req_q.push_back(555116);
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    wait_sig(0, 1'b1, 20, "reset_open_rise");
    chk("reset_open_fail_cnt", 32'(fail_cnt), 32'd0);
    repeat (499) @(posedge hwclk);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_unlock_async", 32'(unlock), 32'd0);
    chk("reset_cmp_in", cmp_in, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_digit_cnt", 32'(digit_cnt), 32'd0);
    chk("reset_cmp_req", 32'(cmp_req), 32'd0);
    repeat (2) @(posedge hwclk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge hwclk);
    #1;

    chk("sb_req_empty", 32'(exp_req_q.size()), 32'd0);
    chk("sb_unlock_empty", 32'(exp_unlock_q.size()), 32'd0);
    chk("sb_lock_empty", 32'(exp_lock_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keylock_ctrl.md
Name: keylock_ctrl

Overview:
- Sequencing controller for the keylock code comparator.
- Accumulates keypad digits into a 32-bit decimal value and presents it on cmp_in.
- Requests a compare on ENTER, then drives the unlock pulse window, failure counting and lockout.
- Sits between the keypad decoder (upstream) and the compare module (downstream), one instance per lock.

Parameters:
- MAX_DIGITS, 8: maximum accepted digits per attempt; legal range 1..9, so 10^9-1 fits in 32 bits.
- UNLOCK_CYCLES, 1000: hwclk cycles that unlock is held high after a match.
- MAX_FAILS, 3: consecutive failed attempts that trigger lockout.
- LOCKOUT_CYCLES, 5000: hwclk cycles that keypad input is ignored while locked out.

Ports:
- hwclk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key_valid  in  1  one-cycle strobe: key_digit is valid.
- key_digit  in  4  BCD digit 0..9; values 10..15 are ignored.
- key_enter  in  1  one-cycle strobe: submit the attempt.
- key_clear  in  1  one-cycle strobe: discard the entry.
- cmp_in  out  32  accumulated value; goes to comparator "in".
- cmp_req  out  1  one-cycle compare request.
- cmp_done  in  1  comparator result valid (validUC).
- cmp_match  in  1  comparator match; sampled only when cmp_done=1.
- unlock  out  1  high for UNLOCK_CYCLES after a match.
- locked_out  out  1  high while in LOCKOUT.
- fail_cnt  out  4  consecutive fail count, saturating at 15.
- digit_cnt  out  4  digits accepted in the current entry.
- busy  out  1  high in CHECK, OPEN, LOCKOUT.

Behaviour:
- Reset (async assert, sync release): state=IDLE. cmp_in=0, cmp_req=0, unlock=0, locked_out=0, fail_cnt=0, digit_cnt=0, busy=0, ovf=0.
- States: IDLE, ENTRY, CHECK, OPEN, LOCKOUT.
- Strobe priority in the same cycle: key_clear > key_enter > key_valid.
- IDLE:
  - Valid digit: cmp_in<=digit, digit_cnt<=1, go to ENTRY.
  - key_enter and key_clear: no effect.
- ENTRY:
  - Valid digit with digit_cnt<MAX_DIGITS: cmp_in<=cmp_in*10+digit (32-bit, no wrap possible), digit_cnt+1.
  - Valid digit with digit_cnt==MAX_DIGITS: digit dropped, sticky ovf<=1.
  - key_clear: cmp_in<=0, digit_cnt<=0, ovf<=0, go to IDLE.
  - key_enter with ovf=1: counts as a failure immediately, no compare is issued.
  - key_enter with ovf=0: cmp_req=1 for exactly one cycle, go to CHECK.
- CHECK:
  - cmp_in is held stable.
  - Keypad strobes are ignored, except key_clear, which aborts to IDLE with fail_cnt unchanged.
  - Waits indefinitely for cmp_done.
  - cmp_done&cmp_match: fail_cnt<=0, go to OPEN.
  - cmp_done&!cmp_match: failure.
- Failure:
  - fail_cnt<=sat(fail_cnt+1); cmp_in, digit_cnt and ovf are cleared.
  - If the new fail_cnt>=MAX_FAILS, go to LOCKOUT; otherwise go to IDLE.
- OPEN:
  - unlock=1 starting the cycle after the match is sampled, for exactly UNLOCK_CYCLES cycles.
  - Keypad is ignored.
  - On expiry, clears the entry and goes to IDLE.
- LOCKOUT:
  - locked_out=1 for exactly LOCKOUT_CYCLES cycles; all keypad strobes are ignored, including key_clear.
  - On expiry: fail_cnt<=0, go to IDLE.
- One shared down-counter serves OPEN and LOCKOUT, width clog2(max(UNLOCK_CYCLES, LOCKOUT_CYCLES)+1).
- Reset asserted mid-operation: immediate return to the reset values above; unlock drops asynchronously.

Optional Feature:
- KEYLOCK_LOCKOUT_EN defined: LOCKOUT behaviour as specified above.
- Not defined:
  - LOCKOUT state and locked_out logic are removed; locked_out is tied to 0.
  - Every failure returns to IDLE, and fail_cnt still counts and saturates.
  - MAX_FAILS and LOCKOUT_CYCLES are unused.

Decomposition:
- Package keylock_pkg holds:
  - the state enum typedef;
  - the constant DIGIT_BASE=10 and the 32-bit code width;
  - the function clog2.
- Sub-module keylock_timer: loadable down-counter with load value, start, and done pulse. It is shared between OPEN and LOCKOUT.

Test Plan:
- Correct code: digits 5,5,5,1,1,6 then enter, comparator code 555116.
  - cmp_in steps 5, 55, 555, 5551, 55511, 555116.
  - One cmp_req.
  - cmp_done&match gives unlock high for exactly 1000 cycles, then IDLE.
- Wrong code: digits 5,5,5,1,1,6,1 then enter.
  - cmp_in=5551161, no match.
  - fail_cnt=1, unlock stays 0, state IDLE, cmp_in=0.
- Lockout: three wrong attempts.
  - locked_out=1 for 5000 cycles; digits and enter during this window have no effect.
  - Afterwards fail_cnt=0.
  - Without KEYLOCK_LOCKOUT_EN: fail_cnt=3 and no lockout.
- Overflow: 10 digits '1' then enter with MAX_DIGITS=8.
  - cmp_in=11111111 and digit_cnt=8.
  - Failure counted with no cmp_req.
- Priority and abort:
  - key_clear together with enter in ENTRY: no cmp_req, return to IDLE.
  - key_clear in CHECK before cmp_done: return to IDLE, fail_cnt unchanged.
- Async reset asserted during OPEN at cycle 500: unlock=0 immediately, all outputs at reset values.
